iot_event_tx: RTL and testbench

- Event source for the active-IoT-devices monitor: watches N_DEV per-device "want active" request levels and emits connect/disconnect events as a change/on_off pulse stream.
- Tracks which devices are currently counted active, so every event it emits is consistent: no double connects, no disconnect of an inactive device.
- Serves at most one event per cycle; round-robin arbitration between devices with outstanding mismatches.
- Sits between the device-status inputs and the monitor's change/on_off inputs, in the same clock domain.

---
 rtl/iot_event_tx.sv | 108 ++++++++++
 tb/tb_iot_event_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iot_event_tx.sv
// Connect/disconnect event source for the active-device monitor: one event per cycle, round-robin.
// Optional IOT_SHADOW_COUNT_EN adds shadow_count, a registered popcount of active_mask.
module iot_event_tx #(
  parameter int N_DEV = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_req,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] active_mask,
  output logic             pending
`ifdef IOT_SHADOW_COUNT_EN
  ,
  output logic [7:0]       shadow_count
`endif
);

  logic [N_DEV-1:0] mismatch;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] sel, hi_sel, lo_sel;
  logic             hi_found;
  logic             fire;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [N_DEV-1:0] active_mask_q, active_mask_d;
`ifdef IOT_SHADOW_COUNT_EN
  logic [7:0]       shadow_count_q, shadow_count_d;
`endif

  assign mismatch = dev_req ^ active_mask_q;
  assign pending  = |mismatch;
  assign fire     = !hold && pending;

  // Scanning downward leaves the lowest hit in each half; the half at/above ptr wins.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_sel   = PTR_W'(i);
        end else begin
          lo_sel = PTR_W'(i);
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    change_d      = 1'b0;
    on_off_d      = 1'b0;
    active_mask_d = active_mask_q;
    ptr_d         = ptr_q;
    if (fire) begin
      change_d = 1'b1;
      for (int i = 0; i < N_DEV; i++) begin
        if (PTR_W'(i) == sel) begin
          on_off_d         = dev_req[i];
          active_mask_d[i] = dev_req[i];
        end
      end
      ptr_d = (int'(sel) == N_DEV - 1) ? '0 : sel + PTR_W'(1);
    end
  end

`ifdef IOT_SHADOW_COUNT_EN
  always_comb begin
    shadow_count_d = shadow_count_q;
    if (fire) begin
      shadow_count_d = on_off_d ? shadow_count_q + 8'd1 : shadow_count_q - 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      change_q      <= 1'b0;
      on_off_q      <= 1'b0;
      active_mask_q <= '0;
      ptr_q         <= '0;
`ifdef IOT_SHADOW_COUNT_EN
      shadow_count_q <= 8'd0;
`endif
    end else begin
      change_q      <= change_d;
      on_off_q      <= on_off_d;
      active_mask_q <= active_mask_d;
      ptr_q         <= ptr_d;
`ifdef IOT_SHADOW_COUNT_EN
      shadow_count_q <= shadow_count_d;
`endif
    end
  end

  assign change      = change_q;
  assign on_off      = on_off_q;
  assign active_mask = active_mask_q;
`ifdef IOT_SHADOW_COUNT_EN
  assign shadow_count = shadow_count_q;
`endif

endmodule

// File: tb/tb_iot_event_tx.sv
// Directed plus random bench for iot_event_tx against a behavioural round-robin event model.
module tb_iot_event_tx;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] dev_req;
  logic         hold;
  logic         change;
  logic         on_off;
  logic [N-1:0] active_mask;
  logic         pending;
`ifdef IOT_SHADOW_COUNT_EN
  logic [7:0]   shadow_count;
`endif

  iot_event_tx #(.N_DEV(N), .PTR_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_req     (dev_req),
    .hold        (hold),
    .change      (change),
    .on_off      (on_off),
    .active_mask (active_mask),
    .pending     (pending)
`ifdef IOT_SHADOW_COUNT_EN
    ,
    .shadow_count(shadow_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: which devices are counted, where the search starts.
  logic [N-1:0] mdl_mask;
  int           mdl_ptr;
  logic         mdl_change;
  logic         mdl_on_off;
  int           mdl_count;
  logic [N-1:0] prev_mask;
  int           dut_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] req, input logic h, input logic r);
    int sel;
    if (r) begin
      mdl_mask = '0; mdl_ptr = 0; mdl_change = 1'b0; mdl_on_off = 1'b0; mdl_count = 0;
    end else if (!h && (req != mdl_mask)) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        int d;
        d = (mdl_ptr + k) % N;
        if (sel < 0 && req[d] != mdl_mask[d]) sel = d;
      end
      mdl_change  = 1'b1;
      mdl_on_off  = req[sel];
      mdl_mask[sel] = req[sel];
      mdl_ptr     = (sel + 1) % N;
      mdl_count   = req[sel] ? mdl_count + 1 : mdl_count - 1;
    end else begin
      mdl_change = 1'b0; mdl_on_off = 1'b0;
    end
  endtask

  // One clock: drive, check live pending, clock, check registered outputs against the model.
  task automatic step(input logic [N-1:0] req, input logic h, input logic r);
    logic [N-1:0] diff;
    dev_req = req; hold = h; rst = r;
    #1;
    check("pending_live", 32'(pending), 32'(|(req ^ mdl_mask)));
    prev_mask = active_mask;
    @(posedge clk);
    model_edge(req, h, r);
    #1;
    check("change", 32'(change), 32'(mdl_change));
    check("on_off", 32'(on_off), 32'(mdl_on_off));
    check("active_mask", 32'(active_mask), 32'(mdl_mask));
`ifdef IOT_SHADOW_COUNT_EN
    check("shadow_count", 32'(shadow_count), 32'(8'(mdl_count)));
    check("shadow_popcount", 32'(shadow_count), 32'($countones(active_mask)));
`endif
    diff = active_mask ^ prev_mask;
    dut_sel = -1;
    for (int i = 0; i < N; i++) if (diff[i]) dut_sel = i;
    $display("t=%0t req=%02h hold=%0b rst=%0b -> change=%0b on_off=%0b mask=%02h sel=%0d pending=%0b",
             $time, req, h, r, change, on_off, active_mask, dut_sel, pending);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         h;
    logic         rs;
    mdl_mask = '0; mdl_ptr = 0; mdl_change = 1'b0; mdl_on_off = 1'b0; mdl_count = 0;
    rst = 1'b1; hold = 1'b0; dev_req = 8'hFF;

    // Reset with every device requesting
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    check("rst_change", 32'(change), 32'd0);
    check("rst_mask", 32'(active_mask), 32'd0);
    check("rst_pending", 32'(pending), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, 1'b0, 1'b0);
      check("burst_order", 32'(dut_sel), 32'(k));
      check("burst_connect", 32'({change, on_off}), 32'b11);
    end
    check("burst_mask", 32'(active_mask), 32'hFF);
    step(8'hFF, 1'b0, 1'b0);
    check("burst_done", 32'(change), 32'd0);
    for (int k = 0; k < 8; k++) step(8'h00, 1'b0, 1'b0);
    check("all_off", 32'(active_mask), 32'd0);

    // Single toggle
    step(8'h04, 1'b0, 1'b0);
    check("tog_on", 32'({change, on_off, active_mask}), 32'({2'b11, 8'h04}));
    step(8'h04, 1'b0, 1'b0);
    check("tog_once", 32'(change), 32'd0);
    step(8'h00, 1'b0, 1'b0);
    check("tog_off", 32'({change, on_off, active_mask}), 32'({2'b10, 8'h00}));
    step(8'h00, 1'b0, 1'b0);

    // Glitch filter: device 7 withdraws before it is served
    step(8'h00, 1'b0, 1'b1);
    step(8'h81, 1'b0, 1'b0);
    check("glitch_first", 32'(dut_sel), 32'd0);
    step(8'h01, 1'b0, 1'b0);
    check("glitch_filtered", 32'(change), 32'd0);
    check("glitch_mask", 32'(active_mask), 32'h01);
    step(8'h00, 1'b0, 1'b0);

    // Hold gates emission only
    for (int k = 0; k < 5; k++) begin
      step(8'h03, 1'b1, 1'b0);
      check("hold_quiet", 32'({change, pending}), 32'b01);
    end
    step(8'h03, 1'b0, 1'b0);
    check("hold_ev1", 32'({change, on_off}), 32'b11);
    step(8'h03, 1'b0, 1'b0);
    check("hold_ev2", 32'({change, on_off}), 32'b11);
    step(8'h03, 1'b0, 1'b0);
    check("hold_drained", 32'({change, pending}), 32'b00);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Park the pointer at 3, then request 0, 3 and 7 together
    step(8'h04, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h89, 1'b0, 1'b0);
    check("rr_first", 32'(dut_sel), 32'd3);
    step(8'h89, 1'b0, 1'b0);
    check("rr_second", 32'(dut_sel), 32'd7);
    step(8'h89, 1'b0, 1'b0);
    check("rr_third", 32'(dut_sel), 32'd0);
    step(8'h89, 1'b0, 1'b0);

    // Reset with four events pending
    step(8'h86, 1'b0, 1'b1);
    check("midrst", 32'({change, active_mask}), 32'd0);
`ifdef IOT_SHADOW_COUNT_EN
    check("midrst_shadow", 32'(shadow_count), 32'd0);
`endif
    for (int k = 0; k < 4; k++) step(8'h86, 1'b0, 1'b0);
    check("midrst_refill", 32'(active_mask), 32'h86);

    // Random traffic with occasional hold and reset
    r = 8'h86;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 1) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
      h  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 49) == 0);
      step(r, h, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
